// File: rtl/dbg_apb_pkg.sv
// rtl/dbg_apb_pkg.sv - shared types and constants for the debug APB master arbiter
//
// Contents:
//   apb_ctl_state_e  transfer sequencer state (IDLE, SETUP, ACCESS, RESP)
//   APB_RSP_OKAY     rsp_err value for a completed transfer
//   APB_RSP_ERR      rsp_err value for a timeout or an unknown slave index
package dbg_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_ctl_state_e;

    localparam logic APB_RSP_OKAY = 1'b0;
    localparam logic APB_RSP_ERR  = 1'b1;

endpackage

// File: rtl/dbg_rr_arbiter.sv
// rtl/dbg_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req  in  N   request vector
//   ptr  in  PW  index of the last granted requester; the search starts at ptr+1
//   gnt  out N   one-hot grant, all zero when nothing requests
module dbg_rr_arbiter
    import dbg_apb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] w_idx;

    // Walk from the farthest candidate (ptr itself) down to the nearest (ptr+1);
    // the nearest requesting candidate is visited last and overwrites the grant.
    always_comb begin
        gnt   = '0;
        w_idx = '0;
        for (int i = N; i >= 1; i--) begin
            w_idx = PW'((int'(ptr) + i) % N);
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbg_apb_master_arb.sv
// rtl/dbg_apb_master_arb.sv - round-robin shared debug APB master for NR_REQ requesters
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           per-requester handshake (req_ready one-hot)
//   req_slave/addr/wr_rd/wdata    packed per-requester payload
//   rsp_valid                     one-hot completion pulse
//   rsp_rdata, rsp_err            response data/status, held until the next response
//   apb_addr/sel/enable/wr_rd/wdata  APB master outputs
//   apb_ready, apb_rdata          APB slave return path
module dbg_apb_master_arb
    import dbg_apb_pkg::*;
#(
    parameter int NR_REQ      = 2,
    parameter int NR_SLAVES   = 1,
    parameter int ADDR_WIDTH  = 5,
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int TIMEOUT     = 255,
    parameter int SIDX_W      = $clog2(NR_SLAVES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NR_REQ-1:0]               req_valid,
    output logic [NR_REQ-1:0]               req_ready,
    input  logic [NR_REQ*SIDX_W-1:0]        req_slave,
    input  logic [NR_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NR_REQ-1:0]               req_wr_rd,
    input  logic [NR_REQ*WDATA_WIDTH-1:0]   req_wdata,
    output logic [NR_REQ-1:0]               rsp_valid,
    output logic [RDATA_WIDTH-1:0]          rsp_rdata,
    output logic                            rsp_err,
    output logic [ADDR_WIDTH-1:0]           apb_addr,
    output logic [NR_SLAVES-1:0]            apb_sel,
    output logic                            apb_enable,
    output logic                            apb_wr_rd,
    output logic [WDATA_WIDTH-1:0]          apb_wdata,
    input  logic                            apb_ready,
    input  logic [RDATA_WIDTH-1:0]          apb_rdata
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_ctl_state_e         r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_gnt_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [NR_SLAVES-1:0]   r_apb_sel;
    logic                   r_apb_enable;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_wr_rd;
    logic [WDATA_WIDTH-1:0] r_wdata;
    logic [NR_REQ-1:0]      r_rsp_valid;
    logic [RDATA_WIDTH-1:0] r_rsp_rdata;
    logic                   r_rsp_err;

    logic [NR_REQ-1:0]      w_gnt;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic [SIDX_W-1:0]      w_sel_slave;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [WDATA_WIDTH-1:0] w_sel_wdata;
    logic                   w_sel_wr;
    logic                   w_bad_slave;

    dbg_rr_arbiter #(
        .N  (NR_REQ),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    assign w_sel_slave = req_slave[int'(w_gnt_idx) * SIDX_W +: SIDX_W];
    assign w_sel_addr  = req_addr[int'(w_gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = req_wdata[int'(w_gnt_idx) * WDATA_WIDTH +: WDATA_WIDTH];
    assign w_sel_wr    = req_wr_rd[w_gnt_idx];
    assign w_bad_slave = (int'(w_sel_slave) >= NR_SLAVES);

    // Grants are only offered from IDLE, so at most one transfer is ever in flight.
    assign req_ready = ((r_state == IDLE) && !rst) ? w_gnt : '0;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign apb_addr   = r_addr;
    assign apb_sel    = r_apb_sel;
    assign apb_enable = r_apb_enable;
    assign apb_wr_rd  = r_wr_rd;
    assign apb_wdata  = r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= PTR_W'(NR_REQ - 1);
            r_gnt_idx    <= '0;
            r_cnt        <= '0;
            r_apb_sel    <= '0;
            r_apb_enable <= 1'b0;
            r_addr       <= '0;
            r_wr_rd      <= 1'b0;
            r_wdata      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_addr    <= w_sel_addr;
                        r_wr_rd   <= w_sel_wr;
                        r_wdata   <= w_sel_wdata;
                        if (w_bad_slave) begin
                            // No slave to address: answer straight away without touching the bus.
                            r_state     <= RESP;
                            r_rsp_valid <= NR_REQ'(1) << w_gnt_idx;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= APB_RSP_ERR;
                        end else begin
                            r_state   <= SETUP;
                            r_apb_sel <= NR_SLAVES'(1) << w_sel_slave;
                        end
                    end
                end
                SETUP: begin
                    r_apb_enable <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= ACCESS;
                end
                ACCESS: begin
                    if (apb_ready) begin
                        r_apb_sel    <= '0;
                        r_apb_enable <= 1'b0;
                        r_rsp_valid  <= NR_REQ'(1) << r_gnt_idx;
                        r_rsp_rdata  <= r_wr_rd ? '0 : apb_rdata;
                        r_rsp_err    <= APB_RSP_OKAY;
                        r_state      <= RESP;
                    end else begin
                        if (r_cnt != CNT_W'(TIMEOUT)) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        // This not-ready cycle is the TIMEOUT-th one in a row.
                        if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_apb_sel    <= '0;
                            r_apb_enable <= 1'b0;
                            r_rsp_valid  <= NR_REQ'(1) << r_gnt_idx;
                            r_rsp_rdata  <= '0;
                            r_rsp_err    <= APB_RSP_ERR;
                            r_state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_ptr       <= r_gnt_idx;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_apb_master_arb.sv
// tb/tb_dbg_apb_master_arb.sv - scoreboard bench for dbg_apb_master_arb
module tb_dbg_apb_master_arb;

    localparam int NR_REQ = 2;
    localparam int NR_SLAVES = 1;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TMO = 8;
    localparam int SW = 1;

    logic clk;
    logic rst;
    logic [NR_REQ-1:0]      req_valid;
    logic [NR_REQ-1:0]      req_ready;
    logic [NR_REQ*SW-1:0]   req_slave;
    logic [NR_REQ*AW-1:0]   req_addr;
    logic [NR_REQ-1:0]      req_wr_rd;
    logic [NR_REQ*DW-1:0]   req_wdata;
    logic [NR_REQ-1:0]      rsp_valid;
    logic [DW-1:0]          rsp_rdata;
    logic                   rsp_err;
    logic [AW-1:0]          apb_addr;
    logic [NR_SLAVES-1:0]   apb_sel;
    logic                   apb_enable;
    logic                   apb_wr_rd;
    logic [DW-1:0]          apb_wdata;
    logic                   apb_ready;
    logic [DW-1:0]          apb_rdata;

    dbg_apb_master_arb #(
        .NR_REQ      (NR_REQ),
        .NR_SLAVES   (NR_SLAVES),
        .ADDR_WIDTH  (AW),
        .WDATA_WIDTH (DW),
        .RDATA_WIDTH (DW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_slave  (req_slave),
        .req_addr   (req_addr),
        .req_wr_rd  (req_wr_rd),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb_addr   (apb_addr),
        .apb_sel    (apb_sel),
        .apb_enable (apb_enable),
        .apb_wr_rd  (apb_wr_rd),
        .apb_wdata  (apb_wdata),
        .apb_ready  (apb_ready),
        .apb_rdata  (apb_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: ready after slv_wait not-ready ACCESS cycles, or never when stuck.
    int   slv_wait;
    logic slv_stuck;
    logic [DW-1:0] slv_rdata;
    int   acc_cnt;

    always @(posedge clk) begin
        if (!apb_enable) acc_cnt <= 0;
        else if (!apb_ready) acc_cnt <= acc_cnt + 1;
    end

    assign apb_ready = apb_enable && !slv_stuck && (acc_cnt >= slv_wait);
    assign apb_rdata = slv_rdata;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  vec;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   glog[$];

    task automatic push_exp(input logic [1:0] vec, input logic [31:0] rdata, input logic err,
                            input int acc, input int lat);
        exp_t e;
        e.vec = vec; e.rdata = rdata; e.err = err; e.acc = acc; e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: samples on the falling edge.
    int   cyc = 0;
    int   grant_cyc = 0;
    int   acc_seen = 0;
    int   n_grants = 0;
    int   n_rsp = 0;
    logic busy = 1'b0;
    logic sel_seen = 1'b0;
    logic [AW-1:0] su_addr;
    logic [DW-1:0] su_wdata;
    logic su_wr;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy = 1'b0;
                acc_seen = 0;
            end else begin
                if (|req_ready) begin
                    check("grant_while_busy", busy, 0);
                    check("ready_onehot", $onehot(req_ready), 1);
                    busy = 1'b1;
                    grant_cyc = cyc;
                    acc_seen = 0;
                    n_grants++;
                    glog.push_back(req_ready[1] ? 1 : 0);
                end
                if (apb_sel != '0) sel_seen = 1'b1;
                if (apb_sel != '0 && !apb_enable) begin
                    su_addr = apb_addr;
                    su_wdata = apb_wdata;
                    su_wr = apb_wr_rd;
                end
                if (apb_enable) acc_seen++;
                if (|rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_vec", rsp_valid, e.vec);
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", rsp_err, e.err);
                        check("access_cycles", acc_seen, e.acc);
                        check("latency", cyc - grant_cyc, e.lat);
                        check("bus_idle_in_resp", {apb_sel, apb_enable}, 0);
                    end
                    busy = 1'b0;
                    acc_seen = 0;
                    n_rsp++;
                end
            end
        end
    end

    task automatic set_req(input int r, input logic slave, input logic [AW-1:0] addr,
                           input logic wr, input logic [DW-1:0] wdata);
        req_slave[r] = slave;
        req_addr[r*AW +: AW] = addr;
        req_wr_rd[r] = wr;
        req_wdata[r*DW +: DW] = wdata;
    endtask

    // Keeps current req_valid until the grant count reaches target, then drops all.
    task automatic hold_until(input int target);
        int k = 0;
        while (n_grants < target && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("grant_wait", n_grants >= target, 1);
        req_valid = '0;
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (n_rsp < target && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("rsp_arrived", n_rsp, target);
    endtask

    initial begin
        int k;
        int tgt;
        int rtgt;
        rst = 1'b1;
        req_valid = 2'b11;
        req_slave = '0;
        req_addr = '0;
        req_wr_rd = '0;
        req_wdata = '0;
        slv_wait = 0;
        slv_stuck = 1'b0;
        slv_rdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_apb_sel", apb_sel, 0);
        check("rst_apb_enable", apb_enable, 0);
        check("rst_apb_addr", apb_addr, 0);
        check("rst_apb_wdata", apb_wdata, 0);
        check("rst_apb_wr_rd", apb_wr_rd, 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single write, zero wait states
        slv_rdata = 32'h5555_AAAA;
        set_req(0, 1'b0, 5'h04, 1'b1, 32'hDEADBEEF);
        push_exp(2'b01, 32'h0, 1'b0, 1, 3);
        req_valid[0] = 1'b1;
        hold_until(1);
        wait_rsp(1);
        check("t1_setup_addr", su_addr, 5'h04);
        check("t1_setup_wdata", su_wdata, 32'hDEADBEEF);
        check("t1_setup_wr", su_wr, 1);

        // 2: read with three wait states
        slv_wait = 3;
        slv_rdata = 32'h12345678;
        set_req(1, 1'b0, 5'h1F, 1'b0, 32'h0);
        push_exp(2'b10, 32'h12345678, 1'b0, 4, 6);
        req_valid[1] = 1'b1;
        hold_until(2);
        wait_rsp(2);
        check("t2_setup_addr", su_addr, 5'h1F);
        slv_rdata = 32'h0BAD_0BAD;
        repeat (3) @(posedge clk);
        #1;
        check("t2_rdata_held", rsp_rdata, 32'h12345678);

        // 3: contention, both held valid
        slv_wait = 0;
        slv_rdata = 32'hCAFEF00D;
        set_req(0, 1'b0, 5'h02, 1'b1, 32'hA5A5A5A5);
        set_req(1, 1'b0, 5'h03, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            push_exp(2'b01, 32'h0, 1'b0, 1, 3);
            push_exp(2'b10, 32'hCAFEF00D, 1'b0, 1, 3);
        end
        glog.delete();
        req_valid = 2'b11;
        hold_until(6);
        wait_rsp(6);
        check("t3_grant_count", glog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) check("t3_rr_order", glog[i], i % 2);
        end

        // 4: timeout on a stuck slave
        slv_stuck = 1'b1;
        slv_rdata = 32'hFFFF_FFFF;
        set_req(1, 1'b0, 5'h07, 1'b0, 32'h0);
        push_exp(2'b10, 32'h0, 1'b1, TMO, TMO + 2);
        req_valid[1] = 1'b1;
        hold_until(7);
        wait_rsp(7);
        repeat (2) @(negedge clk);
        check("t4_bus_idle_after", {apb_sel, apb_enable}, 0);
        check("t4_err_held", rsp_err, 1);
        slv_stuck = 1'b0;
        @(posedge clk); #1;

        // 5: slave index out of range
        sel_seen = 1'b0;
        set_req(0, 1'b1, 5'h09, 1'b1, 32'h1111_2222);
        push_exp(2'b01, 32'h0, 1'b1, 0, 1);
        req_valid[0] = 1'b1;
        hold_until(8);
        wait_rsp(8);
        repeat (2) @(posedge clk);
        #1;
        check("t5_sel_never", sel_seen, 0);

        // 6: reset during ACCESS, then restart
        slv_stuck = 1'b1;
        set_req(1, 1'b0, 5'h0A, 1'b0, 32'h0);
        req_valid[1] = 1'b1;
        hold_until(9);
        k = 0;
        while (!apb_enable && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_access", apb_enable, 1);
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_sel_enable", {apb_sel, apb_enable}, 0);
        check("t6_rst_no_rsp", rsp_valid, 0);
        set_req(0, 1'b0, 5'h11, 1'b1, 32'h0000_0001);
        set_req(1, 1'b0, 5'h12, 1'b1, 32'h0000_0002);
        req_valid = 2'b11;
        @(negedge clk);
        check("t6_ready_forced0", req_ready, 0);
        @(posedge clk); #1;
        slv_stuck = 1'b0;
        push_exp(2'b01, 32'h0, 1'b0, 1, 3);
        push_exp(2'b10, 32'h0, 1'b0, 1, 3);
        glog.delete();
        tgt = n_grants + 2;
        rtgt = n_rsp + 2;
        rst = 1'b0;
        hold_until(tgt);
        wait_rsp(rtgt);
        check("t6_grant_count", glog.size(), 2);
        if (glog.size() > 0) check("t6_first_grant", glog[0], 0);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
